// File: rtl/multicycle_cpu.sv
// Multicycle MIPS-subset CPU: FETCH/DECODE/EXEC/MEM/WB over one shared memory port,
// with a bus watchdog and an absorbing HALT state that reports why it stopped.
module multicycle_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    input  logic [4:0]  dbg_reg_sel,
    output logic [31:0] dbg_reg_data,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [2:0]  state,
    output logic        retire,
    output logic        halted,
    output logic [1:0]  halt_cause
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned WD_W   = 32;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT) - WD_W'(1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_ALIGN   = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t            st;
    logic [XLEN-1:0]   rf [NREG];
    logic [XLEN-1:0]   a_q, b_q, target_q, result_q;
    logic [WD_W-1:0]   wd_q;

    logic [5:0]        op, funct;
    logic [4:0]        rs, rt, rd, wb_dest_c;
    logic [XLEN-1:0]   imm_sext, eff_addr_c, alu_c, fetch_pc_c;
    logic              legal_c, timeout_c, fetch_go_c;

    assign op       = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign funct    = instr[5:0];
    assign imm_sext = {{16{instr[15]}}, instr[15:0]};

    assign state        = st;
    assign dbg_reg_data = (dbg_reg_sel == 5'd0) ? '0 : rf[dbg_reg_sel];

    assign eff_addr_c = a_q + imm_sext;
    assign wb_dest_c  = (op == OP_RTYPE) ? rd : rt;
    // An ack in the same cycle takes precedence over the watchdog firing.
    assign timeout_c  = (TIMEOUT != 0) && (wd_q == WD_LIMIT);

    // Instruction legality and R-type ALU.
    always_comb begin
        legal_c = 1'b0;
        alu_c   = '0;
        case (op)
            OP_RTYPE: begin
                legal_c = 1'b1;
                case (funct)
                    FN_ADD:  alu_c = a_q + b_q;
                    FN_SUB:  alu_c = a_q - b_q;
                    FN_AND:  alu_c = a_q & b_q;
                    FN_OR:   alu_c = a_q | b_q;
                    FN_SLT:  alu_c = {31'd0, $signed(a_q) < $signed(b_q)};
                    default: legal_c = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: legal_c = 1'b1;
            default: legal_c = 1'b0;
        endcase
    end

    // Every path that completes an instruction and starts the next fetch.
    always_comb begin
        fetch_go_c = 1'b0;
        fetch_pc_c = pc;
        case (st)
            S_EXEC: begin
                if (op == OP_BEQ) begin
                    fetch_go_c = 1'b1;
                    fetch_pc_c = (a_q == b_q) ? target_q : pc;
                end else if (op == OP_J) begin
                    fetch_go_c = 1'b1;
                    fetch_pc_c = {pc[31:28], instr[25:0], 2'b00};
                end
            end
            S_MEM:   fetch_go_c = mem_req && mem_ack && mem_we;
            S_WB:    fetch_go_c = 1'b1;
            default: fetch_go_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st         <= S_FETCH;
            pc         <= RESET_PC;
            instr      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            retire     <= 1'b0;
            halted     <= 1'b0;
            halt_cause <= '0;
            wd_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            target_q   <= '0;
            result_q   <= '0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            retire <= 1'b0;
            case (st)
                S_FETCH: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                        wd_q     <= '0;
                    end else if (mem_ack) begin
                        instr   <= mem_rdata;
                        pc      <= pc + 32'd4;
                        mem_req <= 1'b0;
                        st      <= S_DECODE;
                    end else if (timeout_c) begin
                        mem_req    <= 1'b0;
                        halted     <= 1'b1;
                        halt_cause <= CAUSE_TIMEOUT;
                        st         <= S_HALT;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                S_DECODE: begin
                    if (!legal_c) begin
                        halted     <= 1'b1;
                        halt_cause <= CAUSE_ILLEGAL;
                        st         <= S_HALT;
                    end else begin
                        a_q      <= rf[rs];
                        b_q      <= rf[rt];
                        target_q <= pc + {imm_sext[29:0], 2'b00};
                        st       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op)
                        OP_RTYPE: begin
                            result_q <= alu_c;
                            st       <= S_WB;
                        end
                        OP_ADDI: begin
                            result_q <= a_q + imm_sext;
                            st       <= S_WB;
                        end
                        OP_LW, OP_SW: begin
                            if (eff_addr_c[1:0] != 2'b00) begin
                                halted     <= 1'b1;
                                halt_cause <= CAUSE_ALIGN;
                                st         <= S_HALT;
                            end else begin
                                mem_req   <= 1'b1;
                                mem_we    <= (op == OP_SW);
                                mem_addr  <= eff_addr_c;
                                mem_wdata <= b_q;
                                wd_q      <= '0;
                                st        <= S_MEM;
                            end
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (!mem_we) begin
                            result_q <= mem_rdata;
                            st       <= S_WB;
                        end
                    end else if (timeout_c) begin
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        halted     <= 1'b1;
                        halt_cause <= CAUSE_TIMEOUT;
                        st         <= S_HALT;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                S_WB: begin
                    if (wb_dest_c != 5'd0) rf[wb_dest_c] <= result_q;
                end
                default: ;
            endcase
            // Completion overrides the per-state bus updates above.
            if (fetch_go_c) begin
                pc       <= fetch_pc_c;
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= fetch_pc_c;
                wd_q     <= '0;
                retire   <= 1'b1;
                st       <= S_FETCH;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu: ISA-level reference model plus a memory responder with
// configurable/random ack delay; each retire is checked for pc, latency and written register.
module tb_multicycle_cpu;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int unsigned TO     = 4;
    localparam int          NW     = 256;

    logic        clk, reset;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [4:0]  dbg_reg_sel;
    logic [31:0] dbg_reg_data, pc, instr;
    logic [2:0]  state;
    logic        retire, halted;
    logic [1:0]  halt_cause;

    multicycle_cpu #(.RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .dbg_reg_sel(dbg_reg_sel), .dbg_reg_data(dbg_reg_data),
        .pc(pc), .instr(instr), .state(state), .retire(retire),
        .halted(halted), .halt_cause(halt_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image (written by the test sequence) and reference model state.
    logic [31:0] imem  [NW];
    logic [31:0] mmem  [NW];
    logic [31:0] mregs [32];
    logic [31:0] mpc;
    int          errors, checks;
    int          delay_mode;
    bit          hang;

    // Responder-owned state: DUT-side stores since the last reset, wait/stability stats.
    logic [31:0] wr_mem   [NW];
    bit          wr_valid [NW];
    int          wait_total, stab_errs, wr_count, cnt, cur_delay;
    bit          in_req, was_ack, s_we;
    logic [31:0] s_addr, s_wdata, last_wr_addr, last_wr_data;
    logic [7:0]  widx;

    initial begin
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        wait_total = 0;
    end

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            for (int i = 0; i < NW; i++) wr_valid[i] = 1'b0;
            stab_errs = 0;
            wr_count  = 0;
            in_req    = 1'b0;
            mem_ack   = 1'b0;
        end else begin
            was_ack = mem_ack;
            mem_ack = 1'b0;
            if (mem_req !== 1'b1 || was_ack) in_req = 1'b0;
            if (mem_req === 1'b1) begin
                if (!in_req) begin
                    in_req    = 1'b1;
                    cnt       = 0;
                    cur_delay = (delay_mode < 0) ? int'($urandom_range(0, 3)) : delay_mode;
                    s_we      = mem_we;
                    s_addr    = mem_addr;
                    s_wdata   = mem_wdata;
                end else if (mem_we !== s_we || mem_addr !== s_addr || (s_we && mem_wdata !== s_wdata)) begin
                    stab_errs++;
                end
                if (!hang && cnt >= cur_delay) begin
                    mem_ack = 1'b1;
                    widx    = mem_addr[9:2];
                    if (mem_we) begin
                        wr_mem[widx]   = mem_wdata;
                        wr_valid[widx] = 1'b1;
                        wr_count++;
                        last_wr_addr = mem_addr;
                        last_wr_data = mem_wdata;
                    end else begin
                        mem_rdata = wr_valid[widx] ? wr_mem[widx] : imem[widx];
                    end
                end else begin
                    cnt++;
                    wait_total++;
                end
            end
        end
    end

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int word_tgt);
        return {6'h02, 26'(word_tgt)};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < NW; i++) imem[i] = 32'd0;
    endtask

    // Execute one instruction at the ISA level; cause != 0 means the CPU must halt instead.
    task automatic model_step(output int base, output int wbr, output int cause);
        logic [31:0] ins, a, b, se, v, ad;
        logic [5:0]  op, fn;
        int          rs, rt, rd;
        ins = mmem[mpc[9:2]];
        mpc = mpc + 32'd4;
        op  = ins[31:26];
        fn  = ins[5:0];
        rs  = int'(ins[25:21]);
        rt  = int'(ins[20:16]);
        rd  = int'(ins[15:11]);
        se  = {{16{ins[15]}}, ins[15:0]};
        a   = mregs[rs];
        b   = mregs[rt];
        base = 0; wbr = -1; cause = 0; v = '0;
        case (op)
            6'h00: begin
                base = 4;
                case (fn)
                    6'h20: v = a + b;
                    6'h22: v = a - b;
                    6'h24: v = a & b;
                    6'h25: v = a | b;
                    6'h2A: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: cause = 1;
                endcase
                if (cause == 0) begin
                    if (rd != 0) mregs[rd] = v;
                    wbr = rd;
                end
            end
            6'h08: begin
                base = 4;
                if (rt != 0) mregs[rt] = a + se;
                wbr = rt;
            end
            6'h23, 6'h2B: begin
                ad = a + se;
                if (ad[1:0] != 2'b00) cause = 2;
                else if (op == 6'h23) begin
                    base = 5;
                    if (rt != 0) mregs[rt] = mmem[ad[9:2]];
                    wbr = rt;
                end else begin
                    base = 4;
                    mmem[ad[9:2]] = b;
                end
            end
            6'h04: begin
                base = 3;
                if (a == b) mpc = mpc + {se[29:0], 2'b00};
            end
            6'h02: begin
                base = 3;
                mpc = {mpc[31:28], ins[25:0], 2'b00};
            end
            default: cause = 1;
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Reset, then follow n retires against the model (pc, latency, written register).
    task automatic run_prog(input string tag, input int n);
        int cyc, last_cyc, last_wait, got, base, wbr, cause, lat;
        for (int i = 0; i < NW; i++) mmem[i] = imem[i];
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        mpc = RST_PC;
        do_reset();
        cyc = 0; got = 0; last_cyc = 0; last_wait = 0;
        while (got < n && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (retire === 1'b1) begin
                model_step(base, wbr, cause);
                checks++;
                if (cause != 0) begin
                    errors++;
                    $display("FAIL %s unexpected_retire: retire=1 at pc %h, model expected halt cause %0d", tag, pc, cause);
                end
                checks++;
                if (pc !== mpc) begin
                    errors++;
                    $display("FAIL %s pc: got %h expected %h", tag, pc, mpc);
                end
                if (got > 0) begin
                    lat = cyc - last_cyc;
                    checks++;
                    if (lat != base + (wait_total - last_wait)) begin
                        errors++;
                        $display("FAIL %s latency: got %0d expected %0d", tag, lat, base + (wait_total - last_wait));
                    end
                end
                if (wbr >= 0) begin
                    dbg_reg_sel = 5'(wbr);
                    #1;
                    checks++;
                    if (dbg_reg_data !== mregs[wbr]) begin
                        errors++;
                        $display("FAIL %s reg%0d: got %h expected %h", tag, wbr, dbg_reg_data, mregs[wbr]);
                    end
                end
                last_cyc  = cyc;
                last_wait = wait_total;
                got++;
            end
        end
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL %s retire_count: got %0d expected %0d", tag, got, n);
        end
    endtask

    task automatic check_halt(input string tag, input logic [1:0] exp_cause);
        int  base, wbr, cause, cyc;
        bit  saw_retire, saw_req, pc_moved;
        model_step(base, wbr, cause);
        cyc = 0; saw_retire = 0; saw_req = 0; pc_moved = 0;
        while (halted !== 1'b1 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            if (retire === 1'b1) saw_retire = 1;
        end
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL %s halted: got %b expected 1", tag, halted); end
        checks++;
        if (halt_cause !== exp_cause) begin errors++; $display("FAIL %s halt_cause: got %0d expected %0d", tag, halt_cause, exp_cause); end
        checks++;
        if (state !== 3'd5) begin errors++; $display("FAIL %s state: got %0d expected 5", tag, state); end
        checks++;
        if (pc !== mpc) begin errors++; $display("FAIL %s halt_pc: got %h expected %h", tag, pc, mpc); end
        repeat (10) begin
            @(posedge clk); #1;
            if (retire === 1'b1) saw_retire = 1;
            if (mem_req !== 1'b0) saw_req = 1;
            if (pc !== mpc) pc_moved = 1;
        end
        checks++;
        if (saw_retire || saw_req || pc_moved) begin
            errors++;
            $display("FAIL %s frozen: retire_seen=%0d req_seen=%0d pc_moved=%0d expected all 0", tag, saw_retire, saw_req, pc_moved);
        end
    endtask

    task automatic test_reset();
        hang = 1; delay_mode = 0;
        reset = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if (pc !== RST_PC || state !== 3'd0 || instr !== 32'd0) begin
            errors++; $display("FAIL reset_regs: pc=%h state=%0d instr=%h expected %h 0 0", pc, state, instr, RST_PC);
        end
        checks++;
        if (retire !== 1'b0 || halted !== 1'b0 || halt_cause !== 2'd0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL reset_flags: retire=%b halted=%b cause=%0d req=%b expected 0", retire, halted, halt_cause, mem_req);
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== RST_PC) begin
            errors++; $display("FAIL first_fetch: req=%b we=%b addr=%h expected 1 0 %h", mem_req, mem_we, mem_addr, RST_PC);
        end
        @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mem_req !== 1'b0 || state !== 3'd0 || pc !== RST_PC) begin
            errors++; $display("FAIL mid_req_reset: req=%b state=%0d pc=%h expected 0 0 %h", mem_req, state, pc, RST_PC);
        end
        hang = 0;
    endtask

    task automatic test_arith();
        clear_prog();
        imem[0] = enc_i(6'h08, 0, 1, 5);
        imem[1] = enc_i(6'h08, 0, 2, -3);
        imem[2] = enc_r(1, 2, 3, 6'h20);
        imem[3] = enc_r(2, 1, 4, 6'h2A);
        delay_mode = 0;
        run_prog("arith", 4);
        dbg_reg_sel = 5'd3; #1;
        checks++;
        if (dbg_reg_data !== 32'd2) begin errors++; $display("FAIL arith_r3: got %h expected 2", dbg_reg_data); end
        dbg_reg_sel = 5'd4; #1;
        checks++;
        if (dbg_reg_data !== 32'd1) begin errors++; $display("FAIL arith_r4: got %h expected 1", dbg_reg_data); end
    endtask

    task automatic test_mem();
        clear_prog();
        imem[0]  = enc_j(8);
        imem[8]  = enc_i(6'h08, 0, 3, 2);
        imem[9]  = enc_i(6'h2B, 0, 3, 8);
        imem[10] = enc_i(6'h23, 0, 5, 8);
        delay_mode = 3;
        run_prog("mem", 4);
        checks++;
        if (wr_count !== 1 || last_wr_addr !== 32'd8 || last_wr_data !== 32'd2) begin
            errors++; $display("FAIL mem_store: count=%0d addr=%h data=%h expected 1 8 2", wr_count, last_wr_addr, last_wr_data);
        end
        dbg_reg_sel = 5'd5; #1;
        checks++;
        if (dbg_reg_data !== 32'd2) begin errors++; $display("FAIL mem_r5: got %h expected 2", dbg_reg_data); end
        checks++;
        if (stab_errs !== 0) begin errors++; $display("FAIL mem_stable: got %0d unstable cycles expected 0", stab_errs); end
    endtask

    task automatic test_branch();
        clear_prog();
        imem[0] = enc_i(6'h08, 0, 1, 1);
        imem[1] = enc_i(6'h08, 0, 2, 2);
        imem[2] = enc_i(6'h08, 0, 6, 6);
        imem[3] = enc_i(6'h08, 0, 7, 7);
        imem[4] = enc_i(6'h04, 1, 1, -1);
        delay_mode = 0;
        run_prog("beq_loop", 8);
        checks++;
        if (pc !== 32'h10) begin errors++; $display("FAIL beq_loop_pc: got %h expected 00000010", pc); end
        clear_prog();
        imem[0]  = enc_i(6'h08, 0, 1, 1);
        imem[1]  = enc_i(6'h04, 1, 0, 1);
        imem[2]  = enc_i(6'h04, 1, 1, 1);
        imem[3]  = enc_i(6'h08, 0, 9, 9);
        imem[4]  = enc_j(32'h40);
        imem[64] = enc_i(6'h08, 0, 2, 5);
        delay_mode = -1;
        run_prog("branch_jump", 5);
        checks++;
        if (pc !== 32'h104) begin errors++; $display("FAIL jump_pc: got %h expected 00000104", pc); end
        dbg_reg_sel = 5'd9; #1;
        checks++;
        if (dbg_reg_data !== 32'd0) begin errors++; $display("FAIL skipped_r9: got %h expected 0", dbg_reg_data); end
    endtask

    task automatic test_halts();
        delay_mode = 0;
        clear_prog();
        imem[0] = enc_i(6'h08, 0, 1, 5);
        imem[1] = 32'hFC00_0000;
        run_prog("illegal_op", 1);
        check_halt("illegal_op", 2'd1);
        clear_prog();
        imem[0] = enc_r(1, 2, 3, 6'h21);
        run_prog("illegal_fn", 0);
        check_halt("illegal_fn", 2'd1);
        clear_prog();
        imem[0] = enc_i(6'h08, 0, 1, 2);
        imem[1] = enc_i(6'h23, 1, 2, 4);
        run_prog("misaligned", 1);
        check_halt("misaligned", 2'd2);
    endtask

    task automatic test_timeout();
        int req_cycles, w0, cyc;
        clear_prog();
        imem[0] = enc_i(6'h08, 0, 1, 5);
        hang = 1;
        do_reset();
        w0 = wait_total; req_cycles = 0; cyc = 0;
        while (halted !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (halted !== 1'b1 && mem_req === 1'b1) req_cycles++;
        end
        checks++;
        if (halted !== 1'b1 || halt_cause !== 2'd3) begin
            errors++; $display("FAIL timeout_halt: halted=%b cause=%0d expected 1 3", halted, halt_cause);
        end
        checks++;
        if (req_cycles != int'(TO) || (wait_total - w0) != int'(TO)) begin
            errors++; $display("FAIL timeout_waits: req_cycles=%0d waits=%0d expected %0d", req_cycles, wait_total - w0, TO);
        end
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL timeout_req: got %b expected 0", mem_req); end
        hang = 0;
        do_reset();
        checks++;
        if (pc !== RST_PC || halted !== 1'b0 || state !== 3'd0) begin
            errors++; $display("FAIL timeout_recover: pc=%h halted=%b state=%0d expected %h 0 0", pc, halted, state, RST_PC);
        end
        run_prog("timeout_resume", 1);
    endtask

    task automatic test_zero_reg();
        clear_prog();
        imem[0] = enc_i(6'h08, 0, 0, 7);
        delay_mode = 0;
        run_prog("zero_reg", 1);
        dbg_reg_sel = 5'd0; #1;
        checks++;
        if (dbg_reg_data !== 32'd0) begin errors++; $display("FAIL zero_reg: got %h expected 0", dbg_reg_data); end
    endtask

    task automatic test_random();
        logic [5:0] fns [5];
        int r, bad;
        logic [31:0] dw;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        clear_prog();
        for (int i = 0; i < 128; i++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                2, 3, 4: imem[i] = enc_r(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                         int'($urandom_range(0, 7)), fns[$urandom_range(0, 4)]);
                5: imem[i] = enc_i(6'h2B, 0, int'($urandom_range(0, 7)), 32'h300 + 4 * int'($urandom_range(0, 63)));
                6: imem[i] = enc_i(6'h23, 0, int'($urandom_range(1, 7)), 32'h300 + 4 * int'($urandom_range(0, 63)));
                7: imem[i] = enc_i(6'h04, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
                default: imem[i] = enc_i(6'h08, int'($urandom_range(0, 7)), int'($urandom_range(1, 7)), int'($urandom()));
            endcase
        end
        delay_mode = -1;
        run_prog("random", 40);
        bad = 0;
        for (int i = 192; i < NW; i++) begin
            dw = wr_valid[i] ? wr_mem[i] : imem[i];
            if (dw !== mmem[i]) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL random_mem: got %0d differing words expected 0", bad); end
        checks++;
        if (stab_errs !== 0) begin errors++; $display("FAIL random_stable: got %0d unstable cycles expected 0", stab_errs); end
    endtask

    initial begin
        errors = 0; checks = 0;
        reset = 1'b0; dbg_reg_sel = 5'd0;
        hang = 1; delay_mode = 0;
        test_reset();
        test_arith();
        test_mem();
        test_branch();
        test_halts();
        test_timeout();
        test_zero_reg();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles a memory request may wait for mem_ack; 0 disables the watchdog.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 mem_req  output  1  memory request; held high until the cycle mem_ack is high.
REQ-006 mem_we  output  1  1 = write (sw), 0 = read.
REQ-007 mem_addr  output  32  byte address, word-aligned.
REQ-008 mem_wdata  output  32  store data.
REQ-009 mem_rdata  input  32  read data, valid in the cycle mem_ack is high.
REQ-010 mem_ack  input  1  request complete; may be high in the same cycle mem_req rises; ignored while mem_req is low.
REQ-011 dbg_reg_sel  input  5  register index for the debug read port.
REQ-012 dbg_reg_data  output  32  combinational read of register dbg_reg_sel.
REQ-013 pc  output  32  current PC register.
REQ-014 instr  output  32  instruction register.
REQ-015 state  output  3  FSM encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-016 retire  output  1  one-cycle pulse when an instruction completes.
REQ-017 halted  output  1  high while in HALT.
REQ-018 halt_cause  output  2  0 = none, 1 = illegal opcode/funct, 2 = misaligned data address, 3 = bus timeout.

Function
REQ-019 Supported instructions: R-type (op 0x00) add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed); addi 0x08; lw 0x23; sw 0x2B; beq 0x04; j 0x02. Any other opcode, or R-type with any other funct, is illegal.
REQ-020 The block holds 32 x 32-bit registers; $0 reads as 0 and ignores writes; immediates are sign-extended from 16 bits; arithmetic wraps modulo 2^32 with no overflow trap.
REQ-021 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ack: instr<=mem_rdata, pc<=pc+4, go to DECODE.
REQ-022 DECODE: latch A=rs and B=rt; latch target = pc + (sext(imm)<<2), using the already-incremented pc; go to EXEC. An illegal instruction goes to HALT with cause 1.
REQ-023 EXEC transitions:
  - R-type/addi: compute result, go to WB.
  - lw/sw: compute addr = A + sext(imm); if addr[1:0] != 0, go to HALT with cause 2, else go to MEM.
  - beq: if A == B then pc <= target; go to FETCH and pulse retire.
  - j: pc <= {pc[31:28], imm26, 2'b00}; go to FETCH and pulse retire.
REQ-024 MEM: mem_req=1, mem_addr=addr, mem_we=1 for sw with mem_wdata=B; on mem_ack:
  - lw: latch mem_rdata, go to WB.
  - sw: go to FETCH and pulse retire.
REQ-025 WB: write rd (R-type) or rt (addi, lw); go to FETCH and pulse retire.
REQ-026 Zero-wait latency: R-type/addi 4 cycles, lw 5, sw 4, beq 3, j 3; each cycle of ack delay adds one cycle.
REQ-027 Watchdog: a counter clears when mem_req rises and increments each cycle mem_req=1 and mem_ack=0. When it reaches TIMEOUT (nonzero), go to HALT with cause 3 and drop mem_req. The same-cycle timeout-and-ack case counts as ack.
REQ-028 HALT is absorbing until reset: mem_req=0, pc and registers frozen, retire=0, dbg port still functional.
REQ-029 mem_req, mem_we and mem_addr are registered-stable for the whole request; they change only after the ack cycle.

Reset
REQ-030 While reset=0 at a rising edge, the block loads: pc=RESET_PC, state=FETCH, instr=0, all registers=0, retire=0, halted=0, halt_cause=0, watchdog=0; mem_req=0 during reset cycles.
REQ-031 Reset asserted mid-request abandons the request; a late mem_ack after reset is ignored unless mem_req is high.
REQ-032 The first fetch request is issued in the first cycle after reset returns to 1.

Verification
REQ-033 addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1 with zero-wait memory -> $3=2, $4=1, four retire pulses 4 cycles apart.
REQ-034 sw $3,8($0) then lw $5,8($0), ack delayed 3 cycles -> write at addr 8 with data 2, $5=2, mem_req stable throughout each wait.
REQ-035 beq $1,$1,-1 at pc 0x10 -> pc returns to 0x10; beq taken/not-taken and j 0x0000040 -> pc=0x100.
REQ-036 Opcode 0x3F, and lw with addr 0x6 -> halted=1, halt_cause=1 and 2 respectively; no retire, mem_req=0, pc frozen.
REQ-037 TIMEOUT=4 with mem_ack held low -> HALT with cause 3 after exactly 4 wait cycles; reset pulse -> pc=RESET_PC, fetch resumes.
REQ-038 addi $0,$0,7 -> dbg_reg_sel=0 reads 0.
